// File: rtl/fp_status_unit.sv
// rtl/fp_status_unit.sv - FP flag register, condition evaluator and sticky exception tracker.
// Optional feature macro: FP_STATUS_IRQ_EN (registered sticky interrupt).
module fp_status_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flag_valid,
    output logic       flag_ready,
    input  logic       negative,
    input  logic       zero,
    input  logic       overflow,
    input  logic       cout,
    input  logic       inf,
    input  logic       subnormal,
    input  logic       nan,
    input  logic       cond_valid,
    output logic       cond_ready,
    input  logic [3:0] cond_code,
    output logic       result_valid,
    input  logic       result_ready,
    output logic       result,
    output logic       cond_err,
    output logic       timeout,
    output logic [3:0] sticky,
    input  logic       clear_sticky,
    input  logic [3:0] irq_mask,
    output logic       irq
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state, state_n;
    logic   [6:0]   flags_q;
    logic   [6:0]   snap_q;
    logic   [3:0]   code_q;
    logic   [CW-1:0] cnt_q;
    logic           timeout_n;
    logic           flag_acc;
    logic           cond_acc;
    logic           expire;
    logic   [6:0]   flag_in;
    logic   [3:0]   exc_in;
    logic   [1:0]   eval_out;

    // Flag vector layout: {nan, subnormal, inf, cout, overflow, zero, negative}
    assign flag_in  = {nan, subnormal, inf, cout, overflow, zero, negative};
    assign exc_in   = {nan, subnormal, inf, overflow};

    assign flag_ready   = (state == IDLE);
    assign cond_ready   = (state == IDLE);
    assign result_valid = (state == HOLD);
    assign flag_acc     = flag_valid & flag_ready;
    assign cond_acc     = cond_valid & cond_ready;

    // Expires on the TIMEOUT-th HOLD cycle; cnt_q counts completed HOLD cycles.
    assign expire = (TIMEOUT > 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT);

    function automatic logic [1:0] eval_cond(input logic [3:0] code, input logic [6:0] f);
        logic n, z, ov, cs, fi, sb, u;
        logic [1:0] r;
        {u, sb, fi, cs, ov, z, n} = f;
        r = 2'b00;
        case (code)
            4'h0: r[0] = z & ~u;
            4'h1: r[0] = ~z & ~u;
            4'h2: r[0] = n & ~u;
            4'h3: r[0] = (n | z) & ~u;
            4'h4: r[0] = ~n & ~z & ~u;
            4'h5: r[0] = ~n & ~u;
            4'h6: r[0] = u;
            4'h7: r[0] = ~u;
            4'h8: r[0] = fi;
            4'h9: r[0] = sb;
            4'hA: r[0] = ov;
            4'hB: r[0] = cs;
            4'hC: r[0] = 1'b1;
            4'hD: r[0] = 1'b0;
            default: r = 2'b10;
        endcase
        return r;
    endfunction

    assign eval_out = eval_cond(code_q, snap_q);

    always_comb begin
        state_n   = state;
        timeout_n = 1'b0;
        case (state)
            IDLE: if (cond_acc) state_n = EVAL;
            EVAL: state_n = HOLD;
            HOLD: begin
                if (result_ready) begin
                    state_n = IDLE;
                end else if (expire) begin
                    state_n   = IDLE;
                    timeout_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            flags_q  <= '0;
            snap_q   <= '0;
            code_q   <= '0;
            cnt_q    <= '0;
            result   <= 1'b0;
            cond_err <= 1'b0;
            timeout  <= 1'b0;
            sticky   <= '0;
        end else begin
            state   <= state_n;
            timeout <= timeout_n;
            if (flag_acc) flags_q <= flag_in;
            // Snapshot pre-update flags so a same-cycle flag load is not seen by this query
            if (cond_acc) begin
                snap_q <= flags_q;
                code_q <= cond_code;
            end
            if (state == EVAL) begin
                result   <= eval_out[0];
                cond_err <= eval_out[1];
            end
            if (state == HOLD && state_n == HOLD) cnt_q <= cnt_q + 1'b1;
            else cnt_q <= '0;
            if (flag_acc) sticky <= (clear_sticky ? 4'b0000 : sticky) | exc_in;
            else if (clear_sticky) sticky <= 4'b0000;
        end
    end

`ifdef FP_STATUS_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else irq <= |(sticky & irq_mask);
    end
`else
    logic unused_irq_mask;
    assign unused_irq_mask = ^irq_mask;
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_fp_status_unit.sv
// tb/tb_fp_status_unit.sv - directed self-checking bench for fp_status_unit.
module tb_fp_status_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       flag_valid, flag_ready;
    logic       negative, zero, overflow, cout, inf, subnormal, nan;
    logic       cond_valid, cond_ready;
    logic [3:0] cond_code;
    logic       result_valid, result_ready, result, cond_err, timeout;
    logic [3:0] sticky;
    logic       clear_sticky;
    logic [3:0] irq_mask;
    logic       irq;

    int vectors = 0;
    int miscompares = 0;
    int n;
    logic seen;

    always #5 clk = ~clk;

    fp_status_unit #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .flag_valid(flag_valid), .flag_ready(flag_ready),
        .negative(negative), .zero(zero), .overflow(overflow), .cout(cout),
        .inf(inf), .subnormal(subnormal), .nan(nan),
        .cond_valid(cond_valid), .cond_ready(cond_ready), .cond_code(cond_code),
        .result_valid(result_valid), .result_ready(result_ready),
        .result(result), .cond_err(cond_err), .timeout(timeout),
        .sticky(sticky), .clear_sticky(clear_sticky),
        .irq_mask(irq_mask), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [6:0] f);
        {nan, subnormal, inf, cout, overflow, zero, negative} = f;
    endtask

    // f = {nan, subnormal, inf, cout, overflow, zero, negative}
    task automatic load_flags(input logic [6:0] f);
        set_flags(f);
        flag_valid = 1'b1;
        tick();
        flag_valid = 1'b0;
        set_flags(7'h00);
    endtask

    task automatic query(input string tag, input logic [3:0] code, input logic exp_res, input logic exp_err);
        cond_code  = code;
        cond_valid = 1'b1;
        tick();
        cond_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_rv_eval"}, 32'(result_valid), 32'd0);
        tick();
        @(negedge clk);
        chk({tag, "_rv"}, 32'(result_valid), 32'd1);
        chk({tag, "_res"}, 32'(result), 32'(exp_res));
        chk({tag, "_err"}, 32'(cond_err), 32'(exp_err));
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flag_valid = 1'b0; cond_valid = 1'b0; cond_code = 4'h0;
        result_ready = 1'b0; clear_sticky = 1'b0; irq_mask = 4'b0010;
        set_flags(7'h00);
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_flag_ready", 32'(flag_ready), 32'd1);
        chk("rst_cond_ready", 32'(cond_ready), 32'd1);
        chk("rst_rv", 32'(result_valid), 32'd0);
        chk("rst_sticky", 32'(sticky), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        tick();

        // N=1 then LT
        load_flags(7'b0000001);
        query("lt_n", 4'h2, 1'b1, 1'b0);
        query("ge_n", 4'h5, 1'b0, 1'b0);

        // nan + N: LT masked, UN, ORD
        load_flags(7'b1000001);
        query("lt_nan", 4'h2, 1'b0, 1'b0);
        query("un_nan", 4'h6, 1'b1, 1'b0);
        query("ord_nan", 4'h7, 1'b0, 1'b0);
        @(negedge clk);
        chk("sticky_nan", 32'(sticky), 32'h8);
        tick();

        // Z only
        load_flags(7'b0000010);
        query("le_z", 4'h3, 1'b1, 1'b0);
        query("gt_z", 4'h4, 1'b0, 1'b0);
        query("ne_z", 4'h1, 1'b0, 1'b0);
        query("always", 4'hC, 1'b1, 1'b0);
        query("never", 4'hD, 1'b0, 1'b0);

        // inf, subnormal, overflow, cout
        load_flags(7'b0111100);
        query("inf", 4'h8, 1'b1, 1'b0);
        query("sub", 4'h9, 1'b1, 1'b0);
        query("ov", 4'hA, 1'b1, 1'b0);
        query("cs", 4'hB, 1'b1, 1'b0);

        // Simultaneous Z=1 load and EQ query after Z=0 load
        load_flags(7'b0000000);
        set_flags(7'b0000010);
        flag_valid = 1'b1; cond_code = 4'h0; cond_valid = 1'b1;
        tick();
        flag_valid = 1'b0; cond_valid = 1'b0; set_flags(7'h00);
        tick();
        @(negedge clk);
        chk("eq_pre_rv", 32'(result_valid), 32'd1);
        chk("eq_pre_res", 32'(result), 32'd0);
        result_ready = 1'b1; tick(); result_ready = 1'b0;
        query("eq_post", 4'h0, 1'b1, 1'b0);

        // Reserved codes
        query("rsv_e", 4'hE, 1'b0, 1'b1);
        query("rsv_f", 4'hF, 1'b0, 1'b1);

        // Flags offered outside IDLE are ignored
        clear_sticky = 1'b1; tick(); clear_sticky = 1'b0;
        cond_code = 4'h6; cond_valid = 1'b1;
        tick();
        cond_valid = 1'b0;
        set_flags(7'b1000000); flag_valid = 1'b1;
        tick(); tick();
        flag_valid = 1'b0; set_flags(7'h00);
        @(negedge clk);
        chk("busy_flag_ready", 32'(flag_ready), 32'd0);
        chk("busy_sticky", 32'(sticky), 32'd0);
        chk("busy_res", 32'(result), 32'd0);
        result_ready = 1'b1; tick(); result_ready = 1'b0;

        // Timeout with result_ready held low
        cond_code = 4'h7; cond_valid = 1'b1; tick(); cond_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (result_valid) seen = 1'b1; else tick();
        end
        chk("to_rv_rise", 32'(seen), 32'd1);
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (timeout) seen = 1'b1;
        end
        chk("to_seen", 32'(seen), 32'd1);
        chk("to_cycles", 32'(n), 32'd15);
        chk("to_idle", 32'(cond_ready), 32'd1);
        chk("to_rv_low", 32'(result_valid), 32'd0);
        @(negedge clk);
        chk("to_pulse_one", 32'(timeout), 32'd0);

        // result_ready on the 15th HOLD cycle wins
        #1;
        cond_code = 4'h7; cond_valid = 1'b1; tick(); cond_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("win_rv", 32'(result_valid), 32'd1);
        for (int i = 0; i < 14; i++) @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        chk("win_no_to", 32'(timeout), 32'd0);
        chk("win_idle", 32'(cond_ready), 32'd1);
        @(negedge clk);
        chk("win_no_to2", 32'(timeout), 32'd0);
        #1;

        // Sticky accumulate, clear, clear-with-load
        load_flags(7'b1000000);
        load_flags(7'b0010000);
        @(negedge clk);
        chk("sticky_or", 32'(sticky), 32'hA);
        #6;
        clear_sticky = 1'b1;
        load_flags(7'b0000100);
        clear_sticky = 1'b0;
        @(negedge clk);
        chk("sticky_clr_load", 32'(sticky), 32'h1);
        #6;
        clear_sticky = 1'b1; tick(); clear_sticky = 1'b0;
        @(negedge clk);
        chk("sticky_cleared", 32'(sticky), 32'h0);
        #6;

        // Interrupt on inf with mask 0010
        load_flags(7'b0010000);
        @(negedge clk);
        chk("irq_sticky1", 32'(sticky), 32'h2);
        chk("irq_lag", 32'(irq), 32'd0);
        @(negedge clk);
`ifdef FP_STATUS_IRQ_EN
        chk("irq_set", 32'(irq), 32'd1);
`else
        chk("irq_tied", 32'(irq), 32'd0);
`endif
        #6;
        clear_sticky = 1'b1; tick(); clear_sticky = 1'b0;
        @(negedge clk);
        chk("irq_clr_sticky", 32'(sticky), 32'h0);
        @(negedge clk);
        chk("irq_clr", 32'(irq), 32'd0);
        #6;

        // Reset while in EVAL
        load_flags(7'b1000000);
        cond_code = 4'h6; cond_valid = 1'b1; tick(); cond_valid = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (result_valid) seen = 1'b1;
        end
        chk("rst_eval_rv", 32'(seen), 32'd0);
        chk("rst_eval_sticky", 32'(sticky), 32'h0);
        chk("rst_eval_ready", 32'(cond_ready), 32'd1);
        chk("rst_eval_res", 32'(result), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fp_status_unit.md
FP_STATUS_UNIT -- requirements
Module: fp_status_unit

Interface
REQ-001 Parameter TIMEOUT, default 15, is the number of HOLD cycles before an untaken result is dropped; 0 disables the timeout.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flag_valid  input  1  flag bundle from the FP comparator/ALU is valid.
REQ-005 flag_ready  output  1  unit accepts the flag bundle; high only in IDLE.
REQ-006 negative, zero, overflow, cout, inf, subnormal, nan  input  1 each  comparator flag bundle.
REQ-007 cond_valid  input  1  condition query valid.
REQ-008 cond_ready  output  1  query accepted; high only in IDLE.
REQ-009 cond_code  input  4  condition selector.
REQ-010 result_valid  output  1  result and cond_err are valid.
REQ-011 result_ready  input  1  consumer takes the result.
REQ-012 result  output  1  evaluated condition.
REQ-013 cond_err  output  1  reserved cond_code was queried.
REQ-014 timeout  output  1  one-cycle pulse when a result is dropped.
REQ-015 sticky  output  4  sticky exceptions {nan, subnormal, inf, overflow}, with nan as bit 3.
REQ-016 clear_sticky  input  1  clears sticky.
REQ-017 irq_mask  input  4  per-bit interrupt enable for sticky.
REQ-018 irq  output  1  exception interrupt.

Function
REQ-019 A flag bundle SHALL be captured into the internal flag register on flag_valid & flag_ready.
REQ-020 The FSM SHALL have three states, IDLE, EVAL and HOLD, with transitions IDLE->EVAL on cond_valid & cond_ready, EVAL->HOLD unconditionally, HOLD->IDLE on result_ready or on timeout.
REQ-021 The query SHALL be evaluated in EVAL against the flag register as it stood when the query was accepted.
REQ-022 When a flag update and a query are accepted in the same cycle, the query SHALL see the pre-update flags.
REQ-023 result_valid SHALL rise two cycles after acceptance and SHALL be high only in HOLD.
REQ-024 result and cond_err SHALL hold stable while result_valid is high.
REQ-025 Condition codes (N=negative, Z=zero, U=nan): 0 EQ = Z&~U; 1 NE = ~Z&~U; 2 LT = N&~U; 3 LE = (N|Z)&~U; 4 GT = ~N&~Z&~U; 5 GE = ~N&~U; 6 UN = U; 7 ORD = ~U; 8 INF = inf; 9 SUB = subnormal; A OV = overflow; B CS = cout; C ALWAYS = 1; D NEVER = 0.
REQ-026 Codes E and F SHALL return result=0 with cond_err=1; all other codes SHALL return cond_err=0.
REQ-027 A cycle counter SHALL count HOLD cycles.
REQ-028 When TIMEOUT>0 and the counter reaches TIMEOUT without result_ready, the FSM SHALL return to IDLE and pulse timeout for one cycle.
REQ-029 result_ready asserted in the cycle the count reaches TIMEOUT SHALL win, with no timeout pulse.
REQ-030 On each accepted flag bundle, sticky SHALL be ORed with {nan, subnormal, inf, overflow}.
REQ-031 clear_sticky SHALL zero sticky.
REQ-032 When clear_sticky coincides with an accepted flag bundle, sticky SHALL equal the incoming exception bits.
REQ-033 flag_valid outside IDLE SHALL be ignored (not accepted), with flags and sticky unchanged.

Reset
REQ-034 Reset SHALL force state to IDLE and zero the flag register, sticky, the counter, result, cond_err, result_valid, timeout and irq.
REQ-035 Reset mid-query SHALL discard the query with no result_valid.
REQ-036 Reset SHALL take priority over all other inputs in the same cycle.
REQ-037 flag_ready and cond_ready SHALL be high in the first cycle after reset.

Configuration
REQ-038 With FP_STATUS_IRQ_EN defined, irq SHALL be a registered |(sticky & irq_mask), one cycle behind sticky.
REQ-039 Without FP_STATUS_IRQ_EN, irq SHALL be tied 0 and irq_mask ignored, with the port list unchanged.

Verification
REQ-040 Flags N=1,Z=0,U=0 loaded, then query 2 (LT) -> result=1 two cycles after acceptance, cond_err=0.
REQ-041 Flags nan=1,N=1 loaded, then queries 2, 6 and 7 -> results 0, 1 and 0 respectively, and sticky=4'b1000.
REQ-042 Simultaneous Z=1 update and query 0 after a Z=0 load -> result=0; a following query 0 -> result=1.
REQ-043 TIMEOUT=15 with result_ready held low -> a single timeout pulse 15 HOLD cycles after result_valid rises, then IDLE; query E -> result=0, cond_err=1.
REQ-044 FP_STATUS_IRQ_EN defined, irq_mask=4'b0010, inf flag loaded -> irq=1 one cycle after sticky[1]; clear_sticky -> sticky=0 then irq=0; reset asserted in EVAL -> no result_valid, sticky=0.
